// File: rtl/csr_bank.sv
// Machine-mode CSR bank: trap entry/return, interrupt pending/cause, trap vector generation.
// Optional 64-bit mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
module csr_bank #(
   parameter int unsigned NUM_IRQ     = 4,
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               csr_write,
   input  logic [11:0]        csr_waddr,
   input  logic [31:0]        csr_wdata,
   input  logic [11:0]        csr_raddr,
   output logic [31:0]        csr_rdata,
   output logic               illegal_csr,
   input  logic               csr_exception,
   input  logic [31:0]        csr_exception_cause,
   input  logic [31:0]        csr_exception_pc,
   input  logic [31:0]        csr_exception_tval,
   input  logic               csr_mret,
   input  logic               instr_retire,
   input  logic [NUM_IRQ-1:0] irq,
   output logic               irq_pending,
   output logic [31:0]        irq_cause,
   output logic [31:0]        trap_vector,
   output logic [31:0]        csr_mepc,
   output logic               csr_interrupt_en
);

   localparam logic [11:0] AddrMstatus  = 12'h300;
   localparam logic [11:0] AddrMisa     = 12'h301;
   localparam logic [11:0] AddrMie      = 12'h304;
   localparam logic [11:0] AddrMtvec    = 12'h305;
   localparam logic [11:0] AddrMscratch = 12'h340;
   localparam logic [11:0] AddrMepc     = 12'h341;
   localparam logic [11:0] AddrMcause   = 12'h342;
   localparam logic [11:0] AddrMtval    = 12'h343;
   localparam logic [11:0] AddrMip      = 12'h344;
   localparam logic [11:0] AddrMhartid  = 12'hF14;
   localparam logic [31:0] MisaValue    = 32'h4000_0100;

   logic               r_mstatus_mie;
   logic               r_mstatus_mpie;
   logic [NUM_IRQ-1:0] r_mie;
   logic [29:0]        r_mtvec_base;
   logic               r_mtvec_mode;
   logic [31:0]        r_mscratch;
   logic [31:0]        r_mepc;
   logic [31:0]        r_mcause;
   logic [31:0]        r_mtval;

   logic [NUM_IRQ-1:0] w_pend;
   logic [31:0]        w_mie_full;
   logic [31:0]        w_mip_full;
   logic [31:0]        w_mstatus;
   logic [31:0]        w_mtvec;
   logic [31:0]        w_base;
   logic [31:0]        w_vec_cause;
   logic               w_unused;

   // Exception beats mret beats software for the trap-state CSRs only.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mstatus_mie  <= 1'b0;
         r_mstatus_mpie <= 1'b0;
         r_mepc         <= '0;
         r_mcause       <= '0;
         r_mtval        <= '0;
      end else if (csr_exception) begin
         r_mepc         <= {csr_exception_pc[31:2], 2'b00};
         r_mcause       <= csr_exception_cause;
         r_mtval        <= csr_exception_tval;
         r_mstatus_mpie <= r_mstatus_mie;
         r_mstatus_mie  <= 1'b0;
      end else if (csr_mret) begin
         r_mstatus_mie  <= r_mstatus_mpie;
         r_mstatus_mpie <= 1'b1;
      end else if (csr_write) begin
         case (csr_waddr)
            AddrMstatus: begin
               r_mstatus_mie  <= csr_wdata[3];
               r_mstatus_mpie <= csr_wdata[7];
            end
            AddrMepc:    r_mepc   <= {csr_wdata[31:2], 2'b00};
            AddrMcause:  r_mcause <= csr_wdata;
            AddrMtval:   r_mtval  <= csr_wdata;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mie        <= '0;
         r_mtvec_base <= RESET_MTVEC[31:2];
         r_mtvec_mode <= 1'b0;
         r_mscratch   <= '0;
      end else if (csr_write) begin
         case (csr_waddr)
            AddrMie:      r_mie <= csr_wdata[16 +: NUM_IRQ];
            AddrMtvec: begin
               r_mtvec_base <= csr_wdata[31:2];
               // WARL: only direct (0) and vectored (1) modes are accepted
               if (csr_wdata[1:0] == 2'b00) r_mtvec_mode <= 1'b0;
               else if (csr_wdata[1:0] == 2'b01) r_mtvec_mode <= 1'b1;
            end
            AddrMscratch: r_mscratch <= csr_wdata;
            default: ;
         endcase
      end
   end

`ifdef CSR_COUNTERS_EN
   logic [63:0] r_mcycle;
   logic [63:0] r_minstret;

   // A software write to either half replaces that cycle's increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcycle   <= '0;
         r_minstret <= '0;
      end else begin
         if (csr_write && csr_waddr == 12'hB00)      r_mcycle[31:0]  <= csr_wdata;
         else if (csr_write && csr_waddr == 12'hB80) r_mcycle[63:32] <= csr_wdata;
         else                                        r_mcycle <= r_mcycle + 64'd1;

         if (csr_write && csr_waddr == 12'hB02)      r_minstret[31:0]  <= csr_wdata;
         else if (csr_write && csr_waddr == 12'hB82) r_minstret[63:32] <= csr_wdata;
         else if (instr_retire)                      r_minstret <= r_minstret + 64'd1;
      end
   end
`endif

   always_comb begin
      w_mie_full = '0;
      w_mip_full = '0;
      w_mie_full[16 +: NUM_IRQ] = r_mie;
      w_mip_full[16 +: NUM_IRQ] = irq;
   end

   assign w_mstatus = {24'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
   assign w_mtvec   = {r_mtvec_base, 1'b0, r_mtvec_mode};
   assign w_pend    = irq & r_mie;

   assign irq_pending      = r_mstatus_mie & (|w_pend);
   assign csr_mepc         = r_mepc;
   assign csr_interrupt_en = r_mstatus_mie;

   // Lowest pending index wins, so scan downward and let the last hit stick.
   always_comb begin
      irq_cause = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (w_pend[i]) irq_cause = 32'h8000_0000 | 32'(16 + i);
      end
   end

   assign w_base      = {r_mtvec_base, 2'b00};
   assign w_vec_cause = csr_exception ? csr_exception_cause : irq_cause;

   always_comb begin
      trap_vector = w_base;
      if (r_mtvec_mode && !(csr_exception && !csr_exception_cause[31])) begin
         trap_vector = w_base + {w_vec_cause[29:0], 2'b00};
      end
   end

   always_comb begin
      csr_rdata   = '0;
      illegal_csr = 1'b0;
      case (csr_raddr)
         AddrMstatus:  csr_rdata = w_mstatus;
         AddrMisa:     csr_rdata = MisaValue;
         AddrMie:      csr_rdata = w_mie_full;
         AddrMtvec:    csr_rdata = w_mtvec;
         AddrMscratch: csr_rdata = r_mscratch;
         AddrMepc:     csr_rdata = r_mepc;
         AddrMcause:   csr_rdata = r_mcause;
         AddrMtval:    csr_rdata = r_mtval;
         AddrMip:      csr_rdata = w_mip_full;
         AddrMhartid:  csr_rdata = '0;
`ifdef CSR_COUNTERS_EN
         12'hB00:      csr_rdata = r_mcycle[31:0];
         12'hB80:      csr_rdata = r_mcycle[63:32];
         12'hB02:      csr_rdata = r_minstret[31:0];
         12'hB82:      csr_rdata = r_minstret[63:32];
`endif
         default:      illegal_csr = 1'b1;
      endcase
   end

`ifdef CSR_COUNTERS_EN
   assign w_unused = ^{csr_exception_pc[1:0], w_vec_cause[30]};
`else
   assign w_unused = ^{csr_exception_pc[1:0], w_vec_cause[30], instr_retire};
`endif

endmodule
